// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// serial_adder : bit-serial ripple adder, LSB first, one bit per clock.
// Revision     : 1.0
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             s_bit;
  logic             c_bit;

  assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_bit = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last  = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured once on acceptance, so later input changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            res_sh <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_bit;
          res_sh <= {s_bit, res_sh[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum  <= {s_bit, res_sh[WIDTH-1:1]};
            cout <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_serial_adder : directed + exhaustive check of serial_adder (WIDTH 8 and 4).
// Revision        : 1.0
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0 -> WIDTH=8 instance, index 1 -> WIDTH=4 instance.
  logic [1:0]      start_v;
  logic [1:0]      cin_v;
  logic [1:0][7:0] a_v;
  logic [1:0][7:0] b_v;
  wire  [1:0]      busy_v;
  wire  [1:0]      done_v;
  wire  [1:0]      cout_v;
  wire  [1:0][7:0] sum_v;
  wire  [3:0]      sum4;

  assign sum_v[1] = {4'h0, sum4};

  int checks = 0;
  int passes = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0])
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum4), .cout(cout_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an accepted request yields a+b+cin, visible WIDTH cycles later
  // for exactly one done cycle; outputs otherwise hold the last result.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int W = (g == 0) ? 8 : 4;
    int         t = -1;
    logic [8:0] pend = '0;
    logic [7:0] esum = '0;
    logic       ecout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        t = -1; esum = '0; ecout = 1'b0;
      end else if (t < 0) begin
        if (start_v[g]) begin
          t = 0;
          pend = 9'(a_v[g][W-1:0]) + 9'(b_v[g][W-1:0]) + 9'(cin_v[g]);
        end
      end else begin
        t++;
        if (t == W) begin
          esum  = 8'(pend[W-1:0]);
          ecout = pend[W];
        end else if (t == W + 1) begin
          t = -1;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("model_busy_w%0d", W), busy_v[g], (t >= 0 && t < W));
      chk($sformatf("model_done_w%0d", W), done_v[g], (t == W));
      chk($sformatf("model_sum_w%0d", W), sum_v[g], esum);
      chk($sformatf("model_cout_w%0d", W), cout_v[g], ecout);
    end
  end

  task automatic go(input int g, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a_v[g] = a; b_v[g] = b; cin_v[g] = c; start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_v[g]) break;
      if (busy_v[g]) n++;
      @(negedge clk);
    end
    if (!done_v[g]) begin
      checks++;
      $display("FAIL done_timeout: got no done pulse on instance %0d within 60 cycles", g);
    end
  endtask

  initial begin
    int n;
    int seen;
    logic [4:0] ref4;
    rst_n = 1'b0; start_v = '0; cin_v = '0; a_v = '0; b_v = '0;
    #1;
    chk("reset_busy", busy_v[0], 0);
    chk("reset_done", done_v[0], 0);
    chk("reset_sum",  sum_v[0], 0);
    chk("reset_cout", cout_v[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    go(0, 8'h03, 8'h05, 1'b0);
    wait_done(0, n);
    chk("add03_05_busy_cycles", n, 8);
    chk("add03_05_sum",  sum_v[0], 8'h08);
    chk("add03_05_cout", cout_v[0], 1'b0);

    go(0, 8'hFF, 8'h01, 1'b0);
    wait_done(0, n);
    chk("addFF_01_sum",  sum_v[0], 8'h00);
    chk("addFF_01_cout", cout_v[0], 1'b1);

    go(0, 8'h00, 8'h00, 1'b1);
    wait_done(0, n);
    chk("cin_only_sum",  sum_v[0], 8'h01);
    chk("cin_only_cout", cout_v[0], 1'b0);

    // start held high, operands corrupted mid-run
    @(negedge clk);
    a_v[0] = 8'h10; b_v[0] = 8'h20; cin_v[0] = 1'b0; start_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    a_v[0] = 8'hFF; b_v[0] = 8'hFF;
    wait_done(0, n);
    chk("held_start_sum",  sum_v[0], 8'h30);
    chk("held_start_cout", cout_v[0], 1'b0);
    @(negedge clk);
    chk("held_start_idle_gap_busy", busy_v[0], 1'b0);
    chk("held_start_idle_gap_done", done_v[0], 1'b0);
    a_v[0] = 8'h01; b_v[0] = 8'h02;
    @(negedge clk);
    chk("held_start_reaccept_busy", busy_v[0], 1'b1);
    start_v[0] = 1'b0;
    wait_done(0, n);
    chk("second_op_sum",  sum_v[0], 8'h03);
    chk("second_op_cout", cout_v[0], 1'b0);

    // reset in the middle of RUN
    go(0, 8'h55, 8'h0F, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", busy_v[0], 0);
    chk("midrun_reset_done", done_v[0], 0);
    chk("midrun_reset_sum",  sum_v[0], 0);
    chk("midrun_reset_cout", cout_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    chk("midrun_reset_no_done", seen, 0);
    go(0, 8'h7F, 8'h01, 1'b0);
    wait_done(0, n);
    chk("after_reset_sum",  sum_v[0], 8'h80);
    chk("after_reset_cout", cout_v[0], 1'b0);

    // exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          go(1, 8'(ia), 8'(ib), 1'(ic));
          wait_done(1, n);
          ref4 = 5'(ia + ib + ic);
          chk("w4_busy_cycles", n, 4);
          chk("w4_sum",  sum_v[1], {4'h0, ref4[3:0]});
          chk("w4_cout", cout_v[1], ref4[4]);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
